// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port req/ack arbiter sharing one single-port RAM.
// Define MEM_ARB_RR_EN for round-robin tie-breaking (default: port 0 priority).
module mem_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data,
  output logic          m_wren,
  input  logic [DW-1:0] m_q,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  // WAIT counter value on the last wait cycle
  localparam logic [1:0] WLAST = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      wcnt;
  logic            grant;
  logic            cap;
  logic            sel;
  logic            tie_win;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

`ifdef MEM_ARB_RR_EN
  assign tie_win = ~owner;
`else
  assign tie_win = 1'b0;
`endif

  always_comb begin
    sel = 1'b0;
    unique case (1'b1)
      p0_req & p1_req:  sel = tie_win;
      ~p0_req & p1_req: sel = 1'b1;
      default:          sel = 1'b0;
    endcase
  end

  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (p0_req | p1_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (m_wren) begin
          state_nxt = DONE;
        end else if (RD_LAT == 1) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == WLAST) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= (state == WAIT) ? wcnt + 2'd1 : 2'd0;
    end
  end

  // RAM side is registered; only the grant cycle loads new values
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_wren <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      owner  <= 1'b1;
    end else begin
      m_wren <= grant & sel_we;
      if (grant) begin
        m_addr <= sel_addr;
        m_data <= sel_wdata;
        owner  <= sel;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_ack <= (state == DONE) & ~owner;
      p1_ack <= (state == DONE) & owner;
      if (cap & ~owner) p0_rdata <= m_q;
      if (cap & owner)  p1_rdata <= m_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks two arbiters (RD_LAT 1 and 3) against a
// transaction-level model of grant order, ack timing and RAM contents.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  logic          p0_req   [2];
  logic          p0_we    [2];
  logic [AW-1:0] p0_addr  [2];
  logic [DW-1:0] p0_wdata [2];
  logic          p0_ack   [2];
  logic [DW-1:0] p0_rdata [2];
  logic          p1_req   [2];
  logic          p1_we    [2];
  logic [AW-1:0] p1_addr  [2];
  logic [DW-1:0] p1_wdata [2];
  logic          p1_ack   [2];
  logic [DW-1:0] p1_rdata [2];
  logic [AW-1:0] m_addr   [2];
  logic [DW-1:0] m_data   [2];
  logic          m_wren   [2];
  logic [DW-1:0] m_q      [2];
  logic          owner    [2];
  logic          busy     [2];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl    [2][4096];
  logic [DW-1:0] exp_rd [2][2];
  logic          exp_own [2];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] ram [4096];
    logic [DW-1:0] rd;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .p0_req   (p0_req[g]),
      .p0_we    (p0_we[g]),
      .p0_addr  (p0_addr[g]),
      .p0_wdata (p0_wdata[g]),
      .p0_ack   (p0_ack[g]),
      .p0_rdata (p0_rdata[g]),
      .p1_req   (p1_req[g]),
      .p1_we    (p1_we[g]),
      .p1_addr  (p1_addr[g]),
      .p1_wdata (p1_wdata[g]),
      .p1_ack   (p1_ack[g]),
      .p1_rdata (p1_rdata[g]),
      .m_addr   (m_addr[g]),
      .m_data   (m_data[g]),
      .m_wren   (m_wren[g]),
      .m_q      (m_q[g]),
      .owner    (owner[g]),
      .busy     (busy[g])
    );

    initial begin
      for (int k = 0; k < 4096; k++) ram[k] = '0;
    end

    always @(posedge clock) begin
      if (m_wren[g]) ram[m_addr[g]] <= m_data[g];
      d1 <= rd;
      d2 <= d1;
    end

    assign rd = ram[m_addr[g]];
    assign m_q[g] = (LAT == 1) ? rd : ((LAT == 2) ? d1 : d2);
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input int i,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  // n0/n1: how many back-to-back transactions each port keeps requesting
  task automatic run(input int i, input int n0, input int n1,
                     input logic w0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] d0,
                     input logic w1, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d1, input bit glitch);
    int cnt [2];
    int n;
    int samp;
    int ack_at;
    int win;
    logic we_l;
    logic [AW-1:0] a_l;
    logic [DW-1:0] d_l;
    cnt[0] = n0;
    cnt[1] = n1;
    p0_req[i] = (n0 > 0);
    p0_we[i] = w0;
    p0_addr[i] = a0;
    p0_wdata[i] = d0;
    p1_req[i] = (n1 > 0);
    p1_we[i] = w1;
    p1_addr[i] = a1;
    p1_wdata[i] = d1;
    n = 0;
    samp = 1;
    ack_at = 0;
    win = 0;
    we_l = 1'b0;
    a_l = '0;
    d_l = '0;
    while (cnt[0] > 0 || cnt[1] > 0 || n < ack_at) begin
      if (n + 1 == samp) begin
        if (cnt[0] > 0 && cnt[1] > 0)
          win = (RR && exp_own[i] == 1'b0) ? 1 : 0;
        else
          win = (cnt[1] > 0) ? 1 : 0;
        exp_own[i] = win[0];
        we_l = win ? w1 : w0;
        a_l = win ? a1 : a0;
        d_l = win ? d1 : d0;
        ack_at = samp + (we_l ? 2 : 1 + lat_of(i));
      end
      @(posedge clock);
      n++;
      @(negedge clock);
      chk("ack0", i, 32'(p0_ack[i]), 32'(n == ack_at && win == 0));
      chk("ack1", i, 32'(p1_ack[i]), 32'(n == ack_at && win == 1));
      chk("busy", i, 32'(busy[i]), 32'(n >= samp && n < ack_at));
      chk("owner", i, 32'(owner[i]), 32'(exp_own[i]));
      chk("wren", i, 32'(m_wren[i]), 32'(n == samp && we_l));
      if (n == samp) begin
        chk("maddr", i, 32'(m_addr[i]), 32'(a_l));
        if (we_l) begin
          chk("mdata", i, 32'(m_data[i]), 32'(d_l));
          mdl[i][a_l] = d_l;
        end
        if (glitch) begin
          if (win == 0) begin
            p0_req[i] = 1'b0;
            p0_addr[i] = ~a0;
          end else begin
            p1_req[i] = 1'b0;
            p1_addr[i] = ~a1;
          end
          glitch = 1'b0;
        end
      end
      if (n == ack_at) begin
        if (!we_l) exp_rd[i][win] = mdl[i][a_l];
        chk("rdata0", i, 32'(p0_rdata[i]), 32'(exp_rd[i][0]));
        chk("rdata1", i, 32'(p1_rdata[i]), 32'(exp_rd[i][1]));
        if (cnt[win] > 0) cnt[win]--;
        if (cnt[win] == 0) begin
          if (win == 0) p0_req[i] = 1'b0;
          else p1_req[i] = 1'b0;
        end
        samp = n + 1;
      end
      if (n > 100) begin
        chk("timeout", i, 32'(n), 32'(ack_at));
        break;
      end
    end
  endtask

  initial begin
    int n0;
    int n1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p0_req[i] = 1'b0;
      p0_we[i] = 1'b0;
      p0_addr[i] = '0;
      p0_wdata[i] = '0;
      p1_req[i] = 1'b0;
      p1_we[i] = 1'b0;
      p1_addr[i] = '0;
      p1_wdata[i] = '0;
      exp_own[i] = 1'b1;
      exp_rd[i][0] = '0;
      exp_rd[i][1] = '0;
      for (int k = 0; k < 4096; k++) mdl[i][k] = '0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 32'(busy[i]), 32'(0));
      chk("rst_owner", i, 32'(owner[i]), 32'(1));
      chk("rst_wren", i, 32'(m_wren[i]), 32'(0));
      chk("rst_addr", i, 32'(m_addr[i]), 32'(0));
      chk("rst_data", i, 32'(m_data[i]), 32'(0));
      chk("rst_ack0", i, 32'(p0_ack[i]), 32'(0));
      chk("rst_ack1", i, 32'(p1_ack[i]), 32'(0));
      chk("rst_rd0", i, 32'(p0_rdata[i]), 32'(0));
      chk("rst_rd1", i, 32'(p1_rdata[i]), 32'(0));
    end
    reset = 1'b0;

    for (int i = 0; i < 2; i++) begin
      run(i, 1, 0, 1'b1, 12'h010, 16'hBEEF, 1'b0, '0, '0, 1'b0);
      run(i, 0, 1, 1'b0, '0, '0, 1'b0, 12'h010, 16'h0, 1'b0);
      run(i, 2, 2, 1'b1, 12'h020, 16'h1234, 1'b0, 12'h010, 16'h0, 1'b0);
      run(i, 1, 0, 1'b0, 12'h020, '0, 1'b0, '0, '0, 1'b0);
      run(i, 1, 0, 1'b1, 12'h030, 16'h5A5A, 1'b0, '0, '0, 1'b1);
      run(i, 1, 0, 1'b0, 12'h030, '0, 1'b0, '0, '0, 1'b0);
      run(i, 0, 1, 1'b0, '0, '0, 1'b0, 12'hFCF, '0, 1'b0);
      for (int k = 0; k < 40; k++) begin
        n0 = $urandom_range(0, 2);
        n1 = $urandom_range(0, 2);
        if (n0 == 0 && n1 == 0) n0 = 1;
        run(i, n0, n1,
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
            16'($urandom),
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
            16'($urandom), 1'b0);
      end
    end

    for (int i = 0; i < 2; i++) begin
      p0_req[i] = 1'b1;
      p0_we[i] = 1'b1;
      p0_addr[i] = 12'h040;
      p0_wdata[i] = 16'h7777;
    end
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) chk("pre_wren", i, 32'(m_wren[i]), 32'(1));
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("ar_wren", i, 32'(m_wren[i]), 32'(0));
      chk("ar_busy", i, 32'(busy[i]), 32'(0));
      chk("ar_owner", i, 32'(owner[i]), 32'(1));
      chk("ar_rd0", i, 32'(p0_rdata[i]), 32'(0));
      chk("ar_rd1", i, 32'(p1_rdata[i]), 32'(0));
      p0_req[i] = 1'b0;
      exp_own[i] = 1'b1;
      exp_rd[i][0] = '0;
      exp_rd[i][1] = '0;
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        chk("ar_ack0", i, 32'(p0_ack[i]), 32'(0));
        chk("ar_idle", i, 32'(busy[i]), 32'(0));
      end
    end
    for (int i = 0; i < 2; i++)
      run(i, 1, 0, 1'b0, 12'h040, '0, 1'b0, '0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
